// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/fulladder1.sv
// Gate-level 1-bit full-adder cell, reused by the serial adder to process
// one operand bit per clock.
module fulladder1 (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic axb_s;

    assign axb_s = a ^ b;
    assign sum   = axb_s ^ cin;
    assign cout  = (a & b) | (cin & axb_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per clock (LSB first)
// into a single full-adder cell and keeps the running carry in a flip-flop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-2:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [WIDTH-1:0]   acc_ext_s;

    fulladder1 u_fa (
        .sum  (fa_sum_s),
        .cout (fa_cout_s),
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (c_q)
    );

    // New sum bit enters at the top; after the last bit this is the full result.
    assign acc_ext_s = {fa_sum_s, acc_q};

    // Next-state and datapath update for the load / shift / complete sequence.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_ext_s[WIDTH-1:1];
                c_d   = fa_cout_s;
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    sum_d   = acc_ext_s;
                    cout_d  = fa_cout_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
